float_accum_seq: RTL and testbench
==================================

# float_accum_seq

Job sequencer for the `MyFloatAccum` float accumulator unit. It takes a job of `cfg_nvec` vectors of `cfg_len` IEEE-754 single-precision elements from a valid/ready stream and drives the accumulator's `run`, `running`, `delay0`, `in0` and `in1` pins. It pushes one accumulated sum per vector into a small result FIFO with credit-based backpressure. It sits between a stream source (memory reader or upstream unit) and the accumulator, and owns its clear alignment and pipeline draining.

## Interface
- RES_LAT, 4: cycles from accepting the last element of a vector on `acc_in0` to its sum being valid on `acc_out0`.
- RES_DEPTH, 4: result FIFO depth, power of two, ≥2.
- CNT_W, 16: width of length and vector counters.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  job start pulse; sampled only in IDLE
- cfg_len  in  CNT_W  elements per vector; latched at start
- cfg_nvec  in  CNT_W  vectors per job; latched at start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- in_valid / in_ready  in / out  1 / 1  element stream handshake
- in_data  in  32  element (float32)
- res_valid / res_ready  out / in  1 / 1  result stream handshake
- res_data  out  32  vector sum (float32)
- res_last  out  1  result belongs to the last vector of the job
- acc_run, acc_running  out  1  to accumulator `run` and `running`
- acc_delay0  out  32  to accumulator `delay0`; constant 0
- acc_in0  out  32  accumulator data
- acc_in1  out  32  accumulator clear: 32'h1 = clear, else 0
- acc_out0  in  32  accumulator result

## Operation
- States: IDLE, PRIME, STREAM, DRAIN.
- IDLE:
  - On `cfg_start`, latch `cfg_len` and `cfg_nvec`.
  - If either is 0, pulse `done` next cycle and stay IDLE with no `acc_run`.
  - Otherwise go to PRIME. `cfg_start` is ignored in all other states.
- PRIME: one cycle; `acc_run`=1. Next state is STREAM.
- `acc_running` is 1 in PRIME, STREAM and DRAIN; 0 in IDLE.
- STREAM:
  - `in_ready`=1 except when the next element is the last of its vector and `credits == RES_DEPTH`.
  - `credits` = FIFO occupancy + sums in flight.
- An element is accepted when `in_valid && in_ready`.
  - `acc_in0` = `in_data` on an accepted cycle.
  - Otherwise `acc_in0` = 32'h0. These are bubbles, which add +0.0.
- Clear alignment:
  - The first element of each vector is accepted in cycle t.
  - `acc_in1`=32'h1 in cycle t+1 only, via a 1-cycle delay register. This matches the accumulator's in1 latency of 1.
- Counters:
  - Element counter resets to 0 and vector counter increments on the last element of a vector.
  - After the last element of the last vector, go to DRAIN.
- In-flight tracking:
  - A RES_LAT-bit shift register is marked on each last-element accept, carrying a tag for "last vector".
  - When a mark exits, push `acc_out0` and the tag into the FIFO.
- DRAIN: `in_ready`=0. Leave for IDLE when the shift register is empty. `done` pulses in the cycle the final push occurs.
- `busy` = state != IDLE.
- Result FIFO:
  - Push and pop in the same cycle are allowed.
  - A push never overflows, guaranteed by the credits.
  - The FIFO keeps results across job boundaries; a new job may start while it is non-empty.
- The credit check counts pushes and pops of the current cycle combinationally. Simultaneous pop and gate re-opens `in_ready` in the same cycle.

## Timing
- Reset values:
  - state IDLE; counters, shift register and FIFO pointers 0.
  - `busy`, `done`, `in_ready`, `res_valid`, `res_last`, `acc_run`, `acc_running` = 0.
  - `acc_in0`, `acc_in1`, `acc_delay0`, `res_data` = 0.
- `cfg_start` in cycle s, nonzero sizes:
  - PRIME in s+1.
  - First possible accept in s+2.
  - The accumulator's internal delayed start clear lands in s+3, coinciding with the first vector's clear.
- Last element accepted in cycle t: `res_valid` asserted in cycle t+RES_LAT+1 (FIFO registered), if the FIFO was empty.
- Zero-size job: `done` in s+1, `busy` stays 0.
- Back-to-back vectors with no bubbles sustain 1 element/cycle.
- Reset mid-job: all state cleared immediately, FIFO contents dropped, no `done`.

## Test plan
- len=3, nvec=1; in: 0x3F800000, 0x40000000, 0x40400000, no stalls.
  - Expect one result 0x40C00000 (6.0) with `res_last`=1.
  - `done` in the push cycle; `acc_run` seen exactly once, in s+1.
- len=2, nvec=3; pairs (1,1), (2,-1 = 0xBF800000), (3,3), back-to-back.
  - Expect 0x40000000, 0x3F800000, 0x40C00000 in order.
  - `res_last` only on the third result; no sum leaks between vectors.
- Same as the previous job, with `in_valid` toggled 1-0-1 randomly.
  - Results are identical; bubbles contribute 0.
- len=1, nvec=8, `res_ready`=0 throughout.
  - `in_ready` drops after 4 accepts; exactly 4 results are held.
  - Raising `res_ready` releases them all; the 8 results are in order.
- nvec=0, then len=0.
  - Each gives `done` 1 cycle after start, `busy`=0, no `acc_run`, no result.
- `rst` pulsed while in STREAM mid-vector.
  - All outputs return to reset values, FIFO empty, no `done`.
  - A following len=1, nvec=1 job with in=0x40000000 yields 0x40000000.

Source files
------------

// File: rtl/float_accum_seq.sv
// Job sequencer for the MyFloatAccum accumulator: streams vectors into it, aligns the
// clear pin with each vector's first element and collects per-vector sums in a credit-guarded FIFO.
`timescale 1ns/1ps
module float_accum_seq #(
    parameter int RES_LAT   = 4,
    parameter int RES_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_nvec,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_last,
    output logic             acc_run,
    output logic             acc_running,
    output logic [31:0]      acc_delay0,
    output logic [31:0]      acc_in0,
    output logic [31:0]      acc_in1,
    input  logic [31:0]      acc_out0
);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CRD_W = $clog2(RES_DEPTH + RES_LAT + 1) + 1;
    localparam logic [CRD_W-1:0] DEPTH_C = CRD_W'(RES_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   len_r, nvec_r, elem_cnt_r, vec_cnt_r;
    logic [RES_LAT-1:0] mark_r, tag_r;
    logic               clear_r, zero_done_r;
    logic [31:0]        fifo_data_r [RES_DEPTH];
    logic [RES_DEPTH-1:0] fifo_last_r;
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CRD_W-1:0]   count_r, inflight_s, credits_s;
    logic start_s, zero_s, elem_last_s, vec_last_s, fifo_ne_s, pop_s, push_s;
    logic gate_s, in_ready_s, accept_s, final_push_s;

    // Handshake qualifiers, credit check (counts this cycle's pop) and FSM next state/outputs.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RES_LAT; i++) begin
            inflight_s = inflight_s + CRD_W'(mark_r[i]);
        end
        start_s      = (state_r == IDLE) && cfg_start;
        zero_s       = (cfg_len == '0) || (cfg_nvec == '0);
        elem_last_s  = (elem_cnt_r == (len_r - ONE_C));
        vec_last_s   = (vec_cnt_r == (nvec_r - ONE_C));
        fifo_ne_s    = (count_r != '0);
        pop_s        = fifo_ne_s && res_ready;
        push_s       = mark_r[RES_LAT-1];
        credits_s    = count_r + inflight_s - CRD_W'(pop_s);
        gate_s       = elem_last_s && (credits_s >= DEPTH_C);
        in_ready_s   = (state_r == STREAM) && !gate_s;
        accept_s     = in_ready_s && in_valid;
        final_push_s = (state_r == DRAIN) && push_s && (mark_r[RES_LAT-2:0] == '0);

        state_nx_s   = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_start && !zero_s) begin
                    state_nx_s = PRIME;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PRIME:  state_nx_s = STREAM;
            STREAM: begin
                if (accept_s && elem_last_s && vec_last_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = STREAM;
                end
            end
            DRAIN: begin
                if (mark_r[RES_LAT-2:0] == '0) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            default: state_nx_s = IDLE;
        endcase

        busy        = (state_r != IDLE);
        acc_running = (state_r != IDLE);
        acc_run     = (state_r == PRIME);
        done        = zero_done_r || final_push_s;
        in_ready    = in_ready_s;
        acc_in0     = accept_s ? in_data : 32'd0;
        acc_in1     = {31'd0, clear_r};
        acc_delay0  = 32'd0;
        res_valid   = fifo_ne_s;
        res_data    = fifo_data_r[rd_ptr_r];
        res_last    = fifo_ne_s && fifo_last_r[rd_ptr_r];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Job geometry and element/vector position within the job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= '0;
            nvec_r     <= '0;
            elem_cnt_r <= '0;
            vec_cnt_r  <= '0;
        end else if (start_s) begin
            len_r      <= cfg_len;
            nvec_r     <= cfg_nvec;
            elem_cnt_r <= '0;
            vec_cnt_r  <= '0;
        end else if (accept_s) begin
            if (elem_last_s) begin
                elem_cnt_r <= '0;
                vec_cnt_r  <= vec_cnt_r + ONE_C;
            end else begin
                elem_cnt_r <= elem_cnt_r + ONE_C;
            end
        end
    end

    // Clear lags the first element by one cycle; marks track sums through the accumulator latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_r     <= 1'b0;
            zero_done_r <= 1'b0;
            mark_r      <= '0;
            tag_r       <= '0;
        end else begin
            clear_r     <= accept_s && (elem_cnt_r == '0);
            zero_done_r <= start_s && zero_s;
            mark_r      <= {mark_r[RES_LAT-2:0], accept_s && elem_last_s};
            tag_r       <= {tag_r[RES_LAT-2:0], accept_s && elem_last_s && vec_last_s};
        end
    end

    // Result FIFO; overflow is impossible because input is gated on credits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                fifo_data_r[i] <= 32'd0;
            end
            fifo_last_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= acc_out0;
                fifo_last_r[wr_ptr_r] <= tag_r[RES_LAT-1];
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CRD_W'(1);
                2'b01:   count_r <= count_r - CRD_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_float_accum_seq.sv
// Bench for float_accum_seq: integer-valued float vectors, an accumulator model with
// clear latency 1 and result latency 4, and sums predicted from the vectors themselves.
`timescale 1ns/1ps
module tb_float_accum_seq;
    localparam int RES_LAT = 4, RES_DEPTH = 4, CNT_W = 16;

    logic clk = 1'b0, rst;
    logic cfg_start, busy, done, in_valid, in_ready, res_valid, res_ready, res_last;
    logic acc_run, acc_running;
    logic [CNT_W-1:0] cfg_len, cfg_nvec;
    logic [31:0] in_data, res_data, acc_delay0, acc_in0, acc_in1, acc_out0;

    float_accum_seq #(.RES_LAT(RES_LAT), .RES_DEPTH(RES_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_nvec(cfg_nvec),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .acc_run(acc_run), .acc_running(acc_running), .acc_delay0(acc_delay0),
        .acc_in0(acc_in0), .acc_in1(acc_in1), .acc_out0(acc_out0));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int f32_to_int(input logic [31:0] b);
        int e, mag;
        logic [23:0] m;
        if (b[30:0] == 31'd0) return 0;
        e   = int'(b[30:23]) - 127;
        m   = {1'b1, b[22:0]};
        mag = int'(m >> (23 - e));
        return b[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] int_to_f32(input int v);
        int mag, p;
        logic [31:0] mm;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
        mm = 32'(mag) << (23 - p);
        return {(v < 0), 8'(127 + p), mm[22:0]};
    endfunction

    // Accumulator: clear on in1 applies to the previous cycle's in0; sum emerges 4 cycles after its last element.
    int acc_sum_m = 0, acc_prev_m = 0, acc_p1_m = 0, acc_p2_m = 0;
    always @(posedge clk) begin
        if (acc_in1 == 32'h1) acc_sum_m <= acc_prev_m;
        else                  acc_sum_m <= acc_sum_m + acc_prev_m;
        acc_prev_m <= f32_to_int(acc_in0);
        acc_p1_m   <= acc_sum_m;
        acc_p2_m   <= acc_p1_m;
    end
    assign acc_out0 = int_to_f32(acc_p2_m);

    logic [31:0] elems[$];
    logic [31:0] got_q[$];
    bit got_last_q[$];
    int idx, cyc = 0, start_cyc, done_cnt, done_cyc, run_cnt, run_cyc, busy_cnt;
    int last_acc_cyc, first_rv_cyc, bad_cnt, rr_mode;
    bit tog;

    task automatic clr_obs();
        got_q.delete(); got_last_q.delete();
        idx = 0; done_cnt = 0; done_cyc = -1; run_cnt = 0; run_cyc = -1; busy_cnt = 0;
        last_acc_cyc = -1; first_rv_cyc = -1; bad_cnt = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (in_valid && in_ready) begin idx++; last_acc_cyc = cyc; end
        if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (res_valid && res_ready) begin got_q.push_back(res_data); got_last_q.push_back(res_last); end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (acc_run) begin run_cnt++; run_cyc = cyc; end
        if (busy) busy_cnt++;
        if (acc_running !== busy || acc_delay0 !== 32'd0) bad_cnt++;
        @(posedge clk); #1;
        if (idx < elems.size()) begin
            in_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? elems[idx] : $urandom;
        end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
    endtask

    task automatic start_job(input int len, input int nvec);
        cfg_len = CNT_W'(len); cfg_nvec = CNT_W'(nvec); cfg_start = 1'b1; in_valid = 1'b0;
        step();
        start_cyc = cyc;
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input int exp_n, input string tag);
        int lim = 0;
        while (!(done_cnt > 0 && got_q.size() >= exp_n) && lim < 3000) begin step(); lim++; end
        chk({tag, "_timeout"}, 32'(lim < 3000), 32'd1);
        repeat (3) step();
    endtask

    task automatic check_results(input int len, input int nvec, input string tag);
        int exp_n, s;
        exp_n = (len == 0 || nvec == 0) ? 0 : nvec;
        chk({tag, "_nres"}, 32'(got_q.size()), 32'(exp_n));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_running_delay0"}, 32'(bad_cnt), 32'd0);
        for (int v = 0; v < exp_n && v < got_q.size(); v++) begin
            s = 0;
            for (int k = 0; k < len; k++) s += f32_to_int(elems[v * len + k]);
            chk($sformatf("%s_sum%0d", tag, v), got_q[v], int_to_f32(s));
            chk($sformatf("%s_last%0d", tag, v), 32'(got_last_q[v]), 32'(v == exp_n - 1));
        end
    endtask

    task automatic run_job(input int len, input int nvec, input bit t, input int rr, input string tag);
        clr_obs(); tog = t; rr_mode = rr;
        start_job(len, nvec);
        wait_end((len == 0 || nvec == 0) ? 0 : nvec, tag);
        check_results(len, nvec, tag);
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 32'hDEADDEAD;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_last"}, 32'(res_last), 32'd0);
        chk({tag, "_acc_run"}, 32'(acc_run), 32'd0);
        chk({tag, "_acc_running"}, 32'(acc_running), 32'd0);
        chk({tag, "_acc_in0"}, acc_in0, 32'd0);
        chk({tag, "_acc_in1"}, acc_in1, 32'd0);
        chk({tag, "_acc_delay0"}, acc_delay0, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, nvec;
        rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_nvec = '0;
        in_valid = 1'b0; in_data = 32'd0; res_ready = 1'b0; tog = 1'b0; rr_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        // Single vector 1+2+3, latency and single acc_run pulse
        elems = '{32'h3F800000, 32'h40000000, 32'h40400000};
        run_job(3, 1, 1'b0, 0, "t1");
        chk("t1_value", got_at(0), 32'h40C00000);
        chk("t1_run_cnt", 32'(run_cnt), 32'd1);
        chk("t1_run_cyc", 32'(run_cyc), 32'(start_cyc + 1));
        chk("t1_first_accept", 32'(last_acc_cyc - 2), 32'(start_cyc + 2));
        chk("t1_done_cyc", 32'(done_cyc), 32'(last_acc_cyc + RES_LAT));
        chk("t1_res_valid_cyc", 32'(first_rv_cyc), 32'(last_acc_cyc + RES_LAT + 1));

        // Three back-to-back vectors, then the same job with bubbles
        elems = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 32'h40400000};
        for (int r = 0; r < 2; r++) begin
            run_job(2, 3, 1'(r), 0, r == 0 ? "t2" : "t3");
            chk($sformatf("t%0d_r0", r + 2), got_at(0), 32'h40000000);
            chk($sformatf("t%0d_r1", r + 2), got_at(1), 32'h3F800000);
            chk($sformatf("t%0d_r2", r + 2), got_at(2), 32'h40C00000);
        end

        // Randomized jobs with bubbles and random result backpressure
        for (int j = 0; j < 6; j++) begin
            len  = int'($urandom_range(1, 5));
            nvec = int'($urandom_range(1, 4));
            elems.delete();
            for (int k = 0; k < len * nvec; k++)
                elems.push_back(int_to_f32(int'($urandom_range(0, 16)) - 8));
            run_job(len, nvec, 1'($urandom_range(0, 1)), 1, $sformatf("rnd%0d", j));
        end

        // Credit limit: no result consumer
        elems.delete();
        for (int k = 0; k < 8; k++) elems.push_back(int_to_f32(k + 1));
        clr_obs(); tog = 1'b0; rr_mode = 2; res_ready = 1'b0;
        start_job(1, 8);
        repeat (30) step();
        chk("bp_accepts", 32'(idx), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_popped", 32'(got_q.size()), 32'd0);
        rr_mode = 0; res_ready = 1'b1;
        wait_end(8, "bp");
        check_results(1, 8, "bp");

        // Zero-sized jobs
        elems.delete();
        run_job(3, 0, 1'b0, 0, "z_nvec");
        chk("z_nvec_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
        chk("z_nvec_busy", 32'(busy_cnt), 32'd0);
        chk("z_nvec_run", 32'(run_cnt), 32'd0);
        run_job(0, 2, 1'b0, 0, "z_len");
        chk("z_len_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
        chk("z_len_busy", 32'(busy_cnt), 32'd0);
        chk("z_len_run", 32'(run_cnt), 32'd0);

        // Reset in the middle of a vector
        elems.delete();
        for (int k = 0; k < 8; k++) elems.push_back(int_to_f32(k + 2));
        clr_obs(); tog = 1'b0; rr_mode = 0;
        start_job(4, 2);
        for (int i = 0; i < 20 && idx < 2; i++) step();
        chk("rs_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        elems.delete();
        in_valid = 1'b0;
        #1;
        chk_idle("rs");
        done_cnt = 0;
        repeat (3) step();
        rst = 1'b0;
        repeat (8) step();
        chk("rs_no_done", 32'(done_cnt), 32'd0);
        chk("rs_fifo_empty", 32'(res_valid), 32'd0);
        chk("rs_no_results", 32'(got_q.size()), 32'd0);
        elems = '{32'h40000000};
        run_job(1, 1, 1'b0, 0, "rs_after");
        chk("rs_after_value", got_at(0), 32'h40000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
